// File: rtl/rect_plotter.sv
// -----------------------------------------------------------------------------
// rect_plotter
//
// Purpose:
//   Drives a pixel-addressed frame buffer (VGA-adapter style). A request is
//   either a screen clear (one-cycle active-low vga_resetn pulse) or a
//   rectangle fill (one pixel per cycle, row-major). Pixels falling outside the
//   visible SCREEN_W x SCREEN_H area still consume a cycle but are not plotted.
//
// Ports:
//   CLOCK_50    in   sole clock, rising edge
//   reset       in   synchronous, active-high reset
//   req_valid   in   request present
//   req_ready   out  request can be accepted this cycle (combinational)
//   req_clear   in   1 = clear screen, 0 = rectangle fill
//   req_x/y     in   rectangle top-left corner (8 / 7 bits)
//   req_w/h     in   rectangle size in pixels, 0 = empty (8 / 7 bits)
//   req_colour  in   fill colour 0-7
//   x, y        out  pixel address to the display (registered)
//   colour      out  pixel colour to the display (registered)
//   plot        out  write strobe for x/y/colour (registered)
//   vga_resetn  out  active-low display clear (registered)
//   busy        out  request in progress (registered)
//   done        out  one-cycle completion pulse (registered)
// -----------------------------------------------------------------------------
module rect_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_clear,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [7:0] req_w,
  input  logic [6:0] req_h,
  input  logic [2:0] req_colour,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       vga_resetn,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Visible-area limits at the width of the coordinate sums they are compared to.
  localparam logic [8:0] SCREEN_W_L = 9'(SCREEN_W);
  localparam logic [7:0] SCREEN_H_L = 8'(SCREEN_H);

  state_t      state_r;
  logic [7:0]  base_x_r;
  logic [6:0]  base_y_r;
  logic [7:0]  w_r;
  logic [6:0]  h_r;
  logic [7:0]  col_r;   // column offset of the pixel currently on the outputs
  logic [6:0]  row_r;   // row offset of the pixel currently on the outputs

  logic        accept_s;
  logic        col_last_s;
  logic        row_last_s;
  logic [7:0]  next_col_s;
  logic [6:0]  next_row_s;
  logic [7:0]  sel_base_x_s;
  logic [6:0]  sel_base_y_s;
  logic [8:0]  x_sum_s;
  logic [7:0]  y_sum_s;
  logic        visible_s;

  // Handshake: only IDLE accepts, and never while reset is asserted.
  always_comb begin
    req_ready = (state_r == IDLE) && !reset;
    accept_s  = req_valid && req_ready;
  end

  // Address of the next pixel to emit: the first pixel of a newly accepted
  // request, or the row-major successor of the pixel currently shown.
  always_comb begin
    col_last_s = (col_r == (w_r - 8'd1));
    row_last_s = (row_r == (h_r - 7'd1));
    if (accept_s) begin
      next_col_s   = 8'd0;
      next_row_s   = 7'd0;
      sel_base_x_s = req_x;
      sel_base_y_s = req_y;
    end else if (col_last_s) begin
      next_col_s   = 8'd0;
      next_row_s   = row_r + 7'd1;
      sel_base_x_s = base_x_r;
      sel_base_y_s = base_y_r;
    end else begin
      next_col_s   = col_r + 8'd1;
      next_row_s   = row_r;
      sel_base_x_s = base_x_r;
      sel_base_y_s = base_y_r;
    end
    // Sums are one bit wider than the outputs so wrap-around is seen as off-screen.
    x_sum_s   = {1'b0, sel_base_x_s} + {1'b0, next_col_s};
    y_sum_s   = {1'b0, sel_base_y_s} + {1'b0, next_row_s};
    visible_s = (x_sum_s < SCREEN_W_L) && (y_sum_s < SCREEN_H_L);
  end

  // Control FSM with registered display and status outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r    <= IDLE;
      base_x_r   <= 8'd0;
      base_y_r   <= 7'd0;
      w_r        <= 8'd0;
      h_r        <= 7'd0;
      col_r      <= 8'd0;
      row_r      <= 7'd0;
      x          <= 8'd0;
      y          <= 7'd0;
      colour     <= 3'd0;
      plot       <= 1'b0;
      vga_resetn <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          plot       <= 1'b0;
          vga_resetn <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
          if (accept_s) begin
            if (req_clear) begin
              state_r    <= CLEAR;
              vga_resetn <= 1'b0;
              busy       <= 1'b1;
            end else if ((req_w == 8'd0) || (req_h == 7'd0)) begin
              // Empty rectangle: complete immediately, display outputs untouched.
              done <= 1'b1;
            end else begin
              state_r  <= DRAW;
              busy     <= 1'b1;
              base_x_r <= req_x;
              base_y_r <= req_y;
              w_r      <= req_w;
              h_r      <= req_h;
              col_r    <= 8'd0;
              row_r    <= 7'd0;
              x        <= x_sum_s[7:0];
              y        <= y_sum_s[6:0];
              colour   <= req_colour;
              plot     <= visible_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        DRAW: begin
          if (col_last_s && row_last_s) begin
            // Last pixel has just been shown; x/y/colour keep their values.
            state_r <= IDLE;
            plot    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            col_r <= next_col_s;
            row_r <= next_row_s;
            x     <= x_sum_s[7:0];
            y     <= y_sum_s[6:0];
            plot  <= visible_s;
            done  <= 1'b0;
          end
        end

        CLEAR: begin
          state_r    <= IDLE;
          vga_resetn <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b1;
        end

        default: begin
          state_r    <= IDLE;
          plot       <= 1'b0;
          vga_resetn <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// -----------------------------------------------------------------------------
// tb_rect_plotter
//
// Table of requests with expected completion latency, plot count and clear
// pulse count; an independent pixel model pushes every visible pixel into a
// scoreboard queue when a request is driven, and a monitor pops and compares
// on every cycle where plot is high. Hand-written sequences cover reset during
// a fill and back-to-back requests.
// -----------------------------------------------------------------------------
module tb_rect_plotter;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_clear;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [7:0] req_w;
  logic [6:0] req_h;
  logic [2:0] req_colour;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       vga_resetn;
  logic       busy;
  logic       done;

  rect_plotter #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_clear  (req_clear),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .vga_resetn (vga_resetn),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    int clr;
    int x, y, w, h, c;
    int exp_plots;
    int exp_done;
    int exp_vlow;
  } vec_t;

  pix_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   plots_seen = 0;
  int   vlow_seen = 0;
  int   done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: every on-screen pixel of a fill, in row-major order.
  function automatic void push_fill(input int xx, input int yy, input int ww,
                                    input int hh, input int cc);
    for (int r = 0; r < hh; r++) begin
      for (int k = 0; k < ww; k++) begin
        int   xs;
        int   ys;
        pix_t p;
        xs = xx + k;
        ys = yy + r;
        if (xs < 160 && ys < 120) begin
          p.x = xs[7:0];
          p.y = ys[6:0];
          p.c = cc[2:0];
          exp_q.push_back(p);
        end
      end
    end
  endfunction

  // Monitor: scoreboard compare on plotted pixels, plus event counters.
  always @(negedge CLOCK_50) begin
    if (plot === 1'b1) begin
      plots_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d colour=%0d required no plot", x, y, colour);
      end else begin
        pix_t p;
        p = exp_q.pop_front();
        check("pixel_xyc", {14'd0, x, y, colour}, {14'd0, p.x, p.y, p.c});
      end
    end
    if (vga_resetn === 1'b0) vlow_seen++;
    if (done === 1'b1) done_seen++;
  end

  task automatic drive_req(input int clr, input int xx, input int yy, input int ww,
                           input int hh, input int cc);
    req_clear  = clr[0];
    req_x      = xx[7:0];
    req_y      = yy[6:0];
    req_w      = ww[7:0];
    req_h      = hh[6:0];
    req_colour = cc[2:0];
    req_valid  = 1'b1;
    if (clr == 0) push_fill(xx, yy, ww, hh, cc);
  endtask

  // Apply one table vector; called and returns at a falling edge.
  task automatic run_vec(input vec_t v, input string name);
    int   t;
    int   p0, l0, d0;
    int   done_at;
    logic busy1, rdy_done, busy_done;
    t = 0;
    done_at = -1;
    busy1 = 1'bx;
    rdy_done = 1'bx;
    busy_done = 1'bx;
    while (req_ready !== 1'b1 && t < 50) begin
      @(negedge CLOCK_50);
      t++;
    end
    check({name, "_ready_wait"}, 32'(t < 50), 32'd1);
    p0 = plots_seen;
    l0 = vlow_seen;
    d0 = done_seen;
    drive_req(v.clr, v.x, v.y, v.w, v.h, v.c);
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    for (int i = 1; i <= v.exp_done + 2; i++) begin
      if (i == 1) busy1 = busy;
      if (done === 1'b1 && done_at < 0) begin
        done_at   = i;
        rdy_done  = req_ready;
        busy_done = busy;
      end
      @(negedge CLOCK_50);
    end
    check({name, "_done_cycle"}, 32'(done_at), 32'(v.exp_done));
    check({name, "_busy_first"}, {31'd0, busy1}, 32'(v.exp_done > 1));
    check({name, "_ready_at_done"}, {31'd0, rdy_done}, 32'd1);
    check({name, "_busy_at_done"}, {31'd0, busy_done}, 32'd0);
    check({name, "_plot_count"}, 32'(plots_seen - p0), 32'(v.exp_plots));
    check({name, "_vga_low_count"}, 32'(vlow_seen - l0), 32'(v.exp_vlow));
    check({name, "_done_pulses"}, 32'(done_seen - d0), 32'd1);
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    int p0, d0;

    //          clr  x    y   w   h  c  plots done vlow
    vecs[0] = '{0,   10,  20, 2,  2, 5, 4,    5,   0};   // basic 2x2 fill
    vecs[1] = '{0,   158, 119, 4, 2, 3, 2,    9,   0};   // clipped at right/bottom
    vecs[2] = '{0,   30,  40, 0,  5, 1, 0,    1,   0};   // empty, w=0
    vecs[3] = '{1,   0,   0,  0,  0, 0, 0,    2,   1};   // screen clear
    vecs[4] = '{0,   30,  40, 5,  0, 2, 0,    1,   0};   // empty, h=0
    vecs[5] = '{0,   250, 125, 10, 4, 7, 0,   41,  0};   // sums wrap past 8/7 bits
    vecs[6] = '{0,   0,   0,  3,  1, 1, 3,    4,   0};   // top-left corner
    vecs[7] = '{0,   159, 0,  1,  1, 2, 1,    2,   0};   // last visible column
    vecs[8] = '{0,   0,   119, 1, 2, 6, 1,    3,   0};   // last visible row

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_clear  = 1'b0;
    req_x      = 8'd0;
    req_y      = 7'd0;
    req_w      = 8'd0;
    req_h      = 7'd0;
    req_colour = 3'd0;

    // Reset state.
    repeat (3) @(negedge CLOCK_50);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_x", {24'd0, x}, 32'd0);
    check("rst_y", {25'd0, y}, 32'd0);
    check("rst_colour", {29'd0, colour}, 32'd0);
    check("rst_plot", {31'd0, plot}, 32'd0);
    check("rst_vga_resetn", {31'd0, vga_resetn}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_release_ready", {31'd0, req_ready}, 32'd1);
    @(negedge CLOCK_50);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Outputs hold the last DRAW address even when that pixel was off-screen.
    check("hold_x", {24'd0, x}, 32'd0);
    check("hold_y", {25'd0, y}, 32'd120);
    check("hold_colour", {29'd0, colour}, 32'd6);

    // Reset after three pixels of a 4x4 fill.
    p0 = plots_seen;
    d0 = done_seen;
    drive_req(0, 20, 30, 4, 4, 4);
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("abort_plot", {31'd0, plot}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready_in_reset", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("abort_ready_after", {31'd0, req_ready}, 32'd1);
    repeat (6) @(negedge CLOCK_50);
    check("abort_plot_count", 32'(plots_seen - p0), 32'd3);
    check("abort_no_done", 32'(done_seen - d0), 32'd0);
    check("abort_vga_resetn", {31'd0, vga_resetn}, 32'd1);

    // Back-to-back: second request waits through a 1x1 fill, accepted in done cycle.
    d0 = done_seen;
    drive_req(0, 5, 6, 1, 1, 1);
    @(negedge CLOCK_50);                       // cycle 1: 1x1 pixel shown
    drive_req(0, 40, 50, 2, 1, 2);             // held valid while busy
    @(negedge CLOCK_50);                       // cycle 2: done of first
    check("b2b_done", {31'd0, done}, 32'd1);
    check("b2b_ready", {31'd0, req_ready}, 32'd1);
    check("b2b_gap_plot", {31'd0, plot}, 32'd0);
    @(negedge CLOCK_50);                       // cycle 3: first pixel of second
    req_valid = 1'b0;
    check("b2b_plot", {31'd0, plot}, 32'd1);
    check("b2b_x", {24'd0, x}, 32'd40);
    check("b2b_y", {25'd0, y}, 32'd50);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    @(negedge CLOCK_50);                       // cycle 4: second pixel
    @(negedge CLOCK_50);                       // cycle 5: done of second
    check("b2b_done2", {31'd0, done}, 32'd1);
    repeat (3) @(negedge CLOCK_50);
    check("b2b_done_pulses", 32'(done_seen - d0), 32'd2);
    check("b2b_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
